casex_vec_driver: RTL and testbench

CASEX_VEC_DRIVER -- requirements
Module: casex_vec_driver

---
 rtl/casex_vec_driver.sv | 120 ++++++++++++
 tb/tb_casex_vec_driver.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/casex_vec_driver.sv
// Vector-table driver: plays up to 8 stored operand pairs into a decoder,
// waits a settle time, samples the decoder output and tallies mismatches.
module casex_vec_driver #(
    parameter int SETTLE_CYC = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [9:0] wr_data,
    input  logic [3:0] num_vec,
    input  logic       start,
    input  logic [2:0] result,
    output logic [2:0] val1,
    output logic [2:0] val2,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [2:0] fail_idx
);

    typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, SAMPLE, FINISH} state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

    state_t     state, state_nx;
    logic [9:0] tbl [8];
    logic [2:0] idx;
    logic [2:0] prev_res;
    logic [3:0] nv;
    logic [3:0] cnt;
    logic [9:0] ent;
    logic [2:0] exp_eff;
    logic       mism;
    logic       last_vec;

    // entry layout: {hold, exp[2:0], val2[2:0], val1[2:0]}
    assign ent      = tbl[idx];
    assign exp_eff  = ent[9] ? prev_res : ent[8:6];
    assign mism     = (result != exp_eff);
    assign last_vec = ({1'b0, idx} == (nv - 4'd1));

    // table write port; not reset so stored vectors survive a reset
    always_ff @(posedge clk) begin
        if (wr_en && !busy)
            tbl[wr_addr] <= wr_data;
    end

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = (num_vec == 4'd0) ? FINISH : DRIVE;
            DRIVE:   state_nx = SETTLE;
            SETTLE:  if (cnt == SETTLE_LAST) state_nx = SAMPLE;
            SAMPLE:  state_nx = last_vec ? FINISH : DRIVE;
            FINISH:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // datapath and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            val1      <= '0;
            val2      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_idx  <= '0;
            idx       <= '0;
            prev_res  <= '0;
            nv        <= '0;
            cnt       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    nv        <= (num_vec > 4'd8) ? 4'd8 : num_vec;
                    idx       <= '0;
                    err_count <= '0;
                    fail_idx  <= '0;
                    prev_res  <= result;
                    busy      <= 1'b1;
                    pass      <= 1'b0;
                end
                DRIVE: begin
                    val1 <= ent[2:0];
                    val2 <= ent[5:3];
                    cnt  <= '0;
                end
                SETTLE: cnt <= cnt + 4'd1;
                SAMPLE: begin
                    if (mism) begin
                        err_count <= err_count + 4'd1;
                        if (err_count == 4'd0) fail_idx <= idx;
                    end
                    prev_res <= result;
                    if (!last_vec) idx <= idx + 3'd1;
                end
                FINISH: begin
                    // err_count already holds the last sample's update here
                    done <= 1'b1;
                    pass <= (err_count == 4'd0);
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_casex_vec_driver.sv
// Self-checking bench for casex_vec_driver with a behavioural run model.
`timescale 1ns/1ps
module tb_casex_vec_driver;

    localparam int S = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [9:0] wr_data;
    logic [3:0] num_vec;
    logic       start;
    logic [2:0] result;
    logic [2:0] val1, val2;
    logic       busy, done, pass;
    logic [3:0] err_count;
    logic [2:0] fail_idx;

    int n_cmp = 0;
    int n_bad = 0;

    // decoder stand-in: 0 = a&b (correct), 1 = constant hold_val, 2 = stuck at 0
    int         mode = 0;
    logic [2:0] hold_val = 3'b000;

    logic [9:0] tbl [8];
    logic [2:0] ev1 = 3'b000, ev2 = 3'b000;

    casex_vec_driver #(.SETTLE_CYC(S)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .num_vec(num_vec), .start(start), .result(result),
        .val1(val1), .val2(val2), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .fail_idx(fail_idx)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] dec(input logic [2:0] a, input logic [2:0] b,
                                       input int m, input logic [2:0] hv);
        case (m)
            0:       return a & b;
            1:       return hv;
            default: return 3'b000;
        endcase
    endfunction

    always_comb result = dec(val1, val2, mode, hold_val);

    task automatic wr(input logic [2:0] a, input logic [9:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
        tbl[a] = d;
    endtask

    function automatic logic [9:0] ent(input logic h, input logic [2:0] e,
                                       input logic [2:0] v2, input logic [2:0] v1);
        return {h, e, v2, v1};
    endfunction

    // Runs one vector pass; optional same-cycle write with start, optional
    // write+start injection while busy at cycle inj (0 = none).
    task automatic run_and_check(input string name, input logic [3:0] nvec,
                                 input logic sw, input logic [2:0] sa,
                                 input logic [9:0] sd, input int inj);
        int n, e_err, e_fi, e_lat, cyc;
        logic [2:0] prev, r, eff;
        logic [9:0] e;
        bit e_pass;
        if (sw) tbl[sa] = sd;
        n = (nvec > 8) ? 8 : int'(nvec);
        prev = dec(ev1, ev2, mode, hold_val);
        e_err = 0; e_fi = 0;
        for (int i = 0; i < n; i++) begin
            e = tbl[i];
            r = dec(e[2:0], e[5:3], mode, hold_val);
            eff = e[9] ? prev : e[8:6];
            if (r != eff) begin
                if (e_err == 0) e_fi = i;
                e_err++;
            end
            prev = r;
        end
        e_pass = (e_err == 0);
        e_lat = (n == 0) ? 1 : n * (S + 2) + 1;
        if (n > 0) begin ev1 = tbl[n-1][2:0]; ev2 = tbl[n-1][5:3]; end

        @(negedge clk);
        start = 1'b1; num_vec = nvec;
        if (sw) begin wr_en = 1'b1; wr_addr = sa; wr_data = sd; end
        @(negedge clk);
        start = 1'b0; wr_en = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++; $display("FAIL %s busy_after_start: got %b want 1", name, busy);
        end
        cyc = 0;
        while (done !== 1'b1 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            start = 1'b0; wr_en = 1'b0;
            if (inj != 0 && cyc == inj && done !== 1'b1) begin
                start = 1'b1; num_vec = 4'd1;
                wr_en = 1'b1; wr_addr = 3'($urandom_range(0, 7)); wr_data = 10'($urandom);
            end
        end
        start = 1'b0; wr_en = 1'b0;
        n_cmp++;
        if (cyc !== e_lat) begin
            n_bad++; $display("FAIL %s latency: got %0d want %0d", name, cyc, e_lat);
        end
        n_cmp++;
        if (pass !== e_pass || err_count !== 4'(e_err) || fail_idx !== 3'(e_fi) || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s status: got pass=%b err=%0d fi=%0d busy=%b want pass=%b err=%0d fi=%0d busy=0",
                     name, pass, err_count, fail_idx, busy, e_pass, e_err, e_fi);
        end
        n_cmp++;
        if (val1 !== ev1 || val2 !== ev2) begin
            n_bad++; $display("FAIL %s operands: got %b/%b want %b/%b", name, val1, val2, ev1, ev2);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || pass !== e_pass) begin
            n_bad++; $display("FAIL %s done_pulse: got done=%b pass=%b want 0/%b", name, done, pass, e_pass);
        end
    endtask

    task automatic test_reset;
        n_cmp++;
        if ({val1, val2, busy, done, pass, err_count, fail_idx} !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_state: got v1=%b v2=%b busy=%b done=%b pass=%b err=%0d fi=%0d want all 0",
                     val1, val2, busy, done, pass, err_count, fail_idx);
        end
    endtask

    task automatic test_basic;
        mode = 0;
        wr(3'd0, ent(1'b0, 3'b000, 3'b000, 3'b000));
        wr(3'd1, ent(1'b0, 3'b001, 3'b011, 3'b001));
        run_and_check("basic", 4'd2, 1'b0, 3'd0, 10'd0, 0);
    endtask

    task automatic test_mismatch;
        mode = 2;
        run_and_check("mismatch", 4'd2, 1'b0, 3'd0, 10'd0, 0);
        mode = 0;
    endtask

    task automatic test_hold;
        wr(3'd0, ent(1'b0, 3'b001, 3'b001, 3'b001));
        wr(3'd1, ent(1'b1, 3'b000, 3'b010, 3'b111));
        mode = 1; hold_val = 3'b001;
        run_and_check("hold_steady", 4'd2, 1'b0, 3'd0, 10'd0, 0);
        mode = 0;
        run_and_check("hold_change", 4'd2, 1'b0, 3'd0, 10'd0, 0);
    endtask

    task automatic test_bounds;
        for (int i = 0; i < 8; i++)
            wr(3'(i), ent(1'b0, 3'(i & 3), 3'b011, 3'(i)));
        run_and_check("nv_zero", 4'd0, 1'b0, 3'd0, 10'd0, 0);
        run_and_check("nv_twelve", 4'd12, 1'b0, 3'd0, 10'd0, 0);
    endtask

    task automatic test_write_with_start;
        run_and_check("wr_start", 4'd1, 1'b1, 3'd0, ent(1'b0, 3'b101, 3'b111, 3'b110), 0);
    endtask

    task automatic test_busy_ignore;
        run_and_check("busy_ignore", 4'd8, 1'b0, 3'd0, 10'd0, 5);
        // a second pass shows the table was not touched by the busy write
        run_and_check("busy_table", 4'd8, 1'b0, 3'd0, 10'd0, 0);
    endtask

    task automatic test_reset_mid_run;
        int dn;
        for (int i = 0; i < 8; i++)
            wr(3'(i), ent(1'($urandom), 3'($urandom), 3'($urandom), 3'($urandom)));
        @(negedge clk);
        start = 1'b1; num_vec = 4'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (3 * (S + 2) + 1) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        n_cmp++;
        if ({val1, val2, busy, done, pass, err_count, fail_idx} !== 16'd0) begin
            n_bad++;
            $display("FAIL midrun_reset: got v1=%b v2=%b busy=%b done=%b pass=%b err=%0d fi=%0d want all 0",
                     val1, val2, busy, done, pass, err_count, fail_idx);
        end
        ev1 = 3'b000; ev2 = 3'b000;
        dn = 0;
        repeat (2) begin @(negedge clk); if (done) dn++; end
        reset = 1'b0;
        repeat (30) begin @(negedge clk); if (done || busy) dn++; end
        n_cmp++;
        if (dn != 0) begin
            n_bad++; $display("FAIL midrun_no_done: got %0d active cycles want 0", dn);
        end
        run_and_check("after_reset", 4'd5, 1'b0, 3'd0, 10'd0, 0);
    endtask

    task automatic test_random;
        logic [2:0] a, b;
        for (int r = 0; r < 8; r++) begin
            mode = 0;
            for (int i = 0; i < 8; i++) begin
                a = 3'($urandom); b = 3'($urandom);
                wr(3'(i), ent(1'($urandom), ($urandom_range(0, 1) != 0) ? (a & b) : 3'($urandom), b, a));
            end
            run_and_check($sformatf("random%0d", r), 4'($urandom_range(0, 15)), 1'b0, 3'd0, 10'd0, 0);
        end
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        num_vec = '0; start = 1'b0;
        repeat (2) @(negedge clk);
        test_reset;
        reset = 1'b0;
        test_basic;
        test_mismatch;
        test_hold;
        test_bounds;
        test_write_with_start;
        test_busy_ignore;
        test_reset_mid_run;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
